traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Demand-actuated phase scheduler for the four-approach (S, E, N, W) intersection. It grants green to one approach at a time by round-robin over the vehicle-demand inputs and skips approaches with no demand. It enforces minimum and maximum green, a fixed yellow interval and an all-red clearance, and rests on green when there is no competing demand. It drives the four 3-bit lamp buses directly and replaces fixed-time sequencing.

## Interface
- TICK_DIV, 10: clock cycles per timer tick (≥1)
- GREEN_MIN, 5: minimum green, ticks (≥1)
- GREEN_MAX, 15: maximum green under competing demand, ticks (≥GREEN_MIN)
- YELLOW, 4: yellow interval, ticks (≥1)
- ALLRED, 1: all-red clearance, ticks (≥1)
- TW, 8: phase-timer width; all tick parameters < 2^TW
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  4  level vehicle demand; bit 0=S, 1=E, 2=N, 3=W
- preempt  in  4  emergency preemption, same bit order (present only with TRAFFIC_PREEMPT_EN)
- light_S, light_E, light_N, light_W  out  3  lamp code: 100 red, 010 green, 001 yellow
- grant  out  4  one-hot approach currently green or yellow; 0 otherwise
- phase_idx  out  2  index of the last granted approach (round-robin pointer)

## Operation
- States: IDLE (all red, no grant), GREEN, YELLOW, ALLRED. Each state tracks the current approach k.
- All outputs are decoded from registered state. There is no combinational path from input to output.
- **Lamp decode:**
  - Approach k is 010 in GREEN and 001 in YELLOW.
  - Every other lamp is 100 in every state.
- **Round-robin search:**
  - Searches approaches k+1, k+2, k+3, k (mod 4) in that order and picks the first one with req set.
  - In IDLE, the search starts from phase_idx+1.
- **IDLE:**
  - Any req set → GREEN of the selected approach on the next cycle.
  - This transition is not tick-gated.
- **GREEN:**
  - Exits to YELLOW once the minimum green has elapsed and either req[k]=0, or another approach has req set and the maximum green has elapsed.
  - With no demand from other approaches and req[k] held, green is held indefinitely.
- **YELLOW:** exits to ALLRED after YELLOW ticks. req changes during YELLOW are ignored.
- **ALLRED:** after ALLRED ticks, goes to GREEN of the next round-robin winner, or to IDLE if no req is set.
- phase_idx updates on every entry to GREEN.
- **Reset:**
  - Reset values: IDLE, all lamps 100, grant=0, phase_idx=3 (so the first search starts at S), prescaler=0, timer=0.
  - Reset mid-phase forces all-red on the next cycle. No yellow is shown.

## Timing
- The prescaler counts 0..TICK_DIV-1. It asserts tick on the cycle it equals TICK_DIV-1, then wraps. It runs freely from reset.
- The phase timer e clears on every state entry and increments on each tick.
- Exit conditions are evaluated on tick cycles using e+1:
  - GREEN: e+1 ≥ GREEN_MIN, plus the demand terms above; the maximum-green term uses e+1 ≥ GREEN_MAX.
  - YELLOW: e+1 == YELLOW.
  - ALLRED: e+1 == ALLRED.
- With TICK_DIV=1, each state lasts exactly the programmed number of cycles.
- The timer saturates at 2^TW-1 while resting on green.
- req sampled at cycle c in IDLE gives green at cycle c+1.

## Configuration
- TRAFFIC_PREEMPT_EN defined:
  - Any preempt bit set forces the current GREEN to YELLOW on the next cycle, ignoring GREEN_MIN. This does not apply if the current GREEN is already the target approach.
  - After yellow and all-red, the scheduler grants the lowest-index preempt approach.
  - That green is held while its preempt bit stays set, then normal round-robin resumes.
  - preempt asserted in IDLE → GREEN of the target directly.
  - preempt has priority over req at every selection point.
- TRAFFIC_PREEMPT_EN undefined: the preempt port is absent and behaviour is purely demand-actuated.

## Structure
- Shared package traffic_pkg holds:
  - lamp constants LIGHT_RED=3'b100, LIGHT_GREEN=3'b010, LIGHT_YELLOW=3'b001;
  - approach indices S=0, E=1, N=2, W=3;
  - the phase state enum.
- One sub-module, traffic_tick_prescaler (TICK_DIV → single-cycle tick pulse).

## Test plan
All scenarios use TICK_DIV=1, GREEN_MIN=3, GREEN_MAX=6, YELLOW=2, ALLRED=1. Cycle 0 is the first cycle after reset.
- rst high 2 cycles, req=0 → all lamps 100, grant=0, phase_idx=3, and these hold for 20 cycles.
- req=0001 held from cycle 0 → light_S=010 from cycle 1, unchanged through cycle 40 (rest on green).
- req=0011 held from cycle 0:
  - S green cycles 1–6, yellow 7–8, all-red 9;
  - E green from cycle 10, phase_idx=1.
- req=0001 for cycle 0 only → S green 1–3, yellow 4–5, all-red 6, IDLE with all red from cycle 7.
- phase_idx=3 in IDLE, req=0101 → S is granted before N (wrap-around); N is granted after S's yellow and all-red.
- rst asserted during S yellow → all lamps 100 and grant=0 on the next cycle. With TRAFFIC_PREEMPT_EN, preempt=1000 during S green at e=0 → S yellow next cycle, then W green after all-red.

Source files
------------

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the four-approach phase scheduler:
//   - lamp codes driven on the 3-bit lamp buses
//   - approach indices (bit order of req / preempt / grant)
//   - phase state enum
//   - round-robin and priority selection helpers
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_GREEN  = 3'b010;
    localparam logic [2:0] LIGHT_YELLOW = 3'b001;

    localparam logic [1:0] S = 2'd0;
    localparam logic [1:0] E = 2'd1;
    localparam logic [1:0] N = 2'd2;
    localparam logic [1:0] W = 2'd3;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2,
        PH_ALLRED = 2'd3
    } phase_state_e;

    // First requesting approach in the order k+1, k+2, k+3, k (mod 4).
    // Returns k when nothing is requesting; callers gate on |r.
    function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] k);
        logic [1:0] sel;
        logic [1:0] j;
        logic       found;
        sel   = k;
        found = 1'b0;
        for (int unsigned i = 1; i <= 4; i++) begin
            j = k + 2'(i);
            if (!found && r[j]) begin
                sel   = j;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Lowest-index set bit; returns 0 when the vector is empty.
    function automatic logic [1:0] lowest_set(input logic [3:0] v);
        logic [1:0] sel;
        logic       found;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!found && v[i]) begin
                sel   = 2'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/traffic_tick_prescaler.sv
// ---------------------------------------------------------------------------
// traffic_tick_prescaler
// Free-running divider producing a single-cycle tick every TICK_DIV cycles.
// Counter runs 0..TICK_DIV-1; tick is high while it equals TICK_DIV-1.
// With TICK_DIV=1 tick is permanently high.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (counter -> 0)
//   tick  out  timer tick pulse
// ---------------------------------------------------------------------------
module traffic_tick_prescaler #(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_phase_scheduler
// Demand-actuated round-robin phase scheduler for a four-approach
// intersection (S, E, N, W). One approach at a time is green; approaches
// without demand are skipped; min/max green, fixed yellow and all-red
// clearance are enforced; green rests on the current approach while no
// other approach is requesting.
//
// Optional feature macro: TRAFFIC_PREEMPT_EN
//   When defined, a 4-bit preempt input forces the current green to yellow
//   and grants the lowest-index preempting approach next.
//
// Ports:
//   clk                     in   clock
//   rst                     in   synchronous active-high reset
//   req[3:0]                in   level demand, bit0=S 1=E 2=N 3=W
//   preempt[3:0]            in   emergency preemption (TRAFFIC_PREEMPT_EN only)
//   light_S/E/N/W[2:0]      out  lamp code 100 red / 010 green / 001 yellow
//   grant[3:0]              out  one-hot approach in green or yellow
//   phase_idx[1:0]          out  last granted approach (round-robin pointer)
// All outputs decode registered state only.
// ---------------------------------------------------------------------------
module traffic_phase_scheduler #(
    parameter int unsigned TICK_DIV  = 10,
    parameter int unsigned GREEN_MIN = 5,
    parameter int unsigned GREEN_MAX = 15,
    parameter int unsigned YELLOW    = 4,
    parameter int unsigned ALLRED    = 1,
    parameter int unsigned TW        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic [3:0] preempt,
`endif
    output logic [2:0] light_S,
    output logic [2:0] light_E,
    output logic [2:0] light_N,
    output logic [2:0] light_W,
    output logic [3:0] grant,
    output logic [1:0] phase_idx
);

    import traffic_pkg::*;

    localparam logic [TW:0] G_MIN_T  = (TW + 1)'(GREEN_MIN);
    localparam logic [TW:0] G_MAX_T  = (TW + 1)'(GREEN_MAX);
    localparam logic [TW:0] YEL_T    = (TW + 1)'(YELLOW);
    localparam logic [TW:0] ALLRED_T = (TW + 1)'(ALLRED);

    phase_state_e  state_q, state_d;
    logic [1:0]    cur_q, cur_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          tick;
    logic [TW:0]   e_next;
    logic [TW-1:0] timer_inc;
    logic          others_req;
    logic          go_green;
    logic [1:0]    green_sel;
    logic          pre_any;
    logic [1:0]    pre_tgt;
    logic [2:0]    lamp_code;

    traffic_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
`ifdef TRAFFIC_PREEMPT_EN
        pre_any = |preempt;
        pre_tgt = lowest_set(preempt);
`else
        pre_any = 1'b0;
        pre_tgt = '0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PH_IDLE;
            cur_q   <= W;
            idx_q   <= W;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
        end
    end

    // Next-state logic. Exit tests use e+1 so that a state lasts exactly its
    // programmed number of ticks; the timer saturates while resting on green.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        idx_d      = idx_q;
        timer_d    = timer_q;
        go_green   = 1'b0;
        green_sel  = cur_q;
        e_next     = {1'b0, timer_q} + (TW + 1)'(1);
        timer_inc  = (&timer_q) ? timer_q : timer_q + TW'(1);
        others_req = |(req & ~(4'b0001 << cur_q));

        unique case (state_q)
            PH_IDLE: begin
                if (pre_any) begin
                    go_green  = 1'b1;
                    green_sel = pre_tgt;
                end else if (|req) begin
                    go_green  = 1'b1;
                    green_sel = rr_next(req, idx_q);
                end
            end

            PH_GREEN: begin
                if (pre_any && (pre_tgt != cur_q)) begin
                    state_d = PH_YELLOW;
                    timer_d = '0;
                end else if (pre_any) begin
                    // Preempted approach holds green while its preempt stays set.
                    if (tick) begin
                        timer_d = timer_inc;
                    end
                end else if (tick) begin
                    if ((e_next >= G_MIN_T) &&
                        (!req[cur_q] || (others_req && (e_next >= G_MAX_T)))) begin
                        state_d = PH_YELLOW;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            PH_YELLOW: begin
                if (tick) begin
                    if (e_next == YEL_T) begin
                        state_d = PH_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            PH_ALLRED: begin
                if (tick) begin
                    if (e_next == ALLRED_T) begin
                        timer_d = '0;
                        if (pre_any) begin
                            go_green  = 1'b1;
                            green_sel = pre_tgt;
                        end else if (|req) begin
                            go_green  = 1'b1;
                            green_sel = rr_next(req, cur_q);
                        end else begin
                            state_d = PH_IDLE;
                        end
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            default: begin
                state_d = PH_IDLE;
                timer_d = '0;
            end
        endcase

        if (go_green) begin
            state_d = PH_GREEN;
            cur_d   = green_sel;
            idx_d   = green_sel;
            timer_d = '0;
        end
    end

    // Output decode from registered state
    always_comb begin
        lamp_code = (state_q == PH_GREEN) ? LIGHT_GREEN : LIGHT_YELLOW;
        if ((state_q == PH_GREEN) || (state_q == PH_YELLOW)) begin
            grant = 4'b0001 << cur_q;
        end else begin
            grant = '0;
        end
        light_S   = grant[S] ? lamp_code : LIGHT_RED;
        light_E   = grant[E] ? lamp_code : LIGHT_RED;
        light_N   = grant[N] ? lamp_code : LIGHT_RED;
        light_W   = grant[W] ? lamp_code : LIGHT_RED;
        phase_idx = idx_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
module tb_traffic_phase_scheduler;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LG = 3'b010;
    localparam logic [2:0] LY = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
    logic [3:0] preempt = 4'b0000;
`endif

    logic [2:0] a_s, a_e, a_n, a_w;
    logic [3:0] a_grant;
    logic [1:0] a_idx;
    logic [2:0] b_s, b_e, b_n, b_w;
    logic [3:0] b_grant;
    logic [1:0] b_idx;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .TICK_DIV (1), .GREEN_MIN (3), .GREEN_MAX (6), .YELLOW (2), .ALLRED (1), .TW (8)
    ) dut (
        .clk (clk), .rst (rst), .req (req),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt (preempt),
`endif
        .light_S (a_s), .light_E (a_e), .light_N (a_n), .light_W (a_w),
        .grant (a_grant), .phase_idx (a_idx)
    );

    traffic_phase_scheduler #(
        .TICK_DIV (3), .GREEN_MIN (2), .GREEN_MAX (4), .YELLOW (2), .ALLRED (2), .TW (8)
    ) dut_b (
        .clk (clk), .rst (rst), .req (req),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt (preempt),
`endif
        .light_S (b_s), .light_E (b_e), .light_N (b_n), .light_W (b_w),
        .grant (b_grant), .phase_idx (b_idx)
    );

    // ---------------- reference model (one per DUT configuration) ----------
    // mode: 0 idle, 1 green, 2 yellow, 3 all-red; dur counts elapsed ticks.
    int unsigned p_div  [2] = '{1, 3};
    int unsigned p_gmin [2] = '{3, 2};
    int unsigned p_gmax [2] = '{6, 4};
    int unsigned p_yel  [2] = '{2, 2};
    int unsigned p_ar   [2] = '{1, 2};

    int unsigned m_mode [2];
    int unsigned m_k    [2];
    int unsigned m_ptr  [2];
    int unsigned m_dur  [2];
    int unsigned m_cyc  [2];

    function automatic int unsigned pick(input logic [3:0] r, input int unsigned from);
        for (int unsigned i = 1; i <= 4; i++) begin
            if (r[(from + i) % 4]) return (from + i) % 4;
        end
        return from;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_mode[m] = 0; m_k[m] = 3; m_ptr[m] = 3; m_dur[m] = 0; m_cyc[m] = 0;
        end
    endtask

    task automatic model_step(input logic r_rst, input logic [3:0] r);
        bit tk;
        for (int m = 0; m < 2; m++) begin
            if (r_rst) begin
                m_mode[m] = 0; m_k[m] = 3; m_ptr[m] = 3; m_dur[m] = 0; m_cyc[m] = 0;
            end else begin
                tk = ((m_cyc[m] % p_div[m]) == p_div[m] - 1);
                m_cyc[m]++;
                case (m_mode[m])
                    0: if (r != 0) begin
                        m_k[m] = pick(r, m_ptr[m]); m_ptr[m] = m_k[m];
                        m_mode[m] = 1; m_dur[m] = 0;
                    end
                    1: if (tk) begin
                        m_dur[m]++;
                        if (m_dur[m] >= p_gmin[m] &&
                            (!r[m_k[m]] || (((r & ~(4'b0001 << m_k[m])) != 0) && m_dur[m] >= p_gmax[m]))) begin
                            m_mode[m] = 2; m_dur[m] = 0;
                        end
                    end
                    2: if (tk) begin
                        m_dur[m]++;
                        if (m_dur[m] == p_yel[m]) begin m_mode[m] = 3; m_dur[m] = 0; end
                    end
                    default: if (tk) begin
                        m_dur[m]++;
                        if (m_dur[m] == p_ar[m]) begin
                            m_dur[m] = 0;
                            if (r != 0) begin
                                m_k[m] = pick(r, m_k[m]); m_ptr[m] = m_k[m]; m_mode[m] = 1;
                            end else begin
                                m_mode[m] = 0;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    function automatic logic [17:0] pack(input logic [2:0] w, input logic [2:0] n,
                                         input logic [2:0] e, input logic [2:0] s,
                                         input logic [3:0] g, input logic [1:0] i);
        return {w, n, e, s, g, i};
    endfunction

    function automatic logic [17:0] model_out(input int m);
        logic [2:0] lamp [4];
        logic [3:0] g;
        g = 4'b0000;
        for (int a = 0; a < 4; a++) lamp[a] = LR;
        if (m_mode[m] == 1) begin lamp[m_k[m]] = LG; g[m_k[m]] = 1'b1; end
        if (m_mode[m] == 2) begin lamp[m_k[m]] = LY; g[m_k[m]] = 1'b1; end
        return pack(lamp[3], lamp[2], lamp[1], lamp[0], g, 2'(m_ptr[m]));
    endfunction

    // ---------------- checking helpers -------------------------------------
    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (W N E S grant idx)", name, act, exp);
        end
    endtask

    function automatic logic [17:0] out_a();
        return {a_w, a_n, a_e, a_s, a_grant, a_idx};
    endfunction

    function automatic logic [17:0] out_b();
        return {b_w, b_n, b_e, b_s, b_grant, b_idx};
    endfunction

    // Leaves the bench at the negedge of cycle 0 with rst low.
    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
`ifdef TRAFFIC_PREEMPT_EN
        preempt = 4'b0000;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic advance(input logic r_rst, input logic [3:0] r);
        rst = r_rst;
        req = r;
        model_step(r_rst, r);
        @(negedge clk);
    endtask

    // ---------------- directed vector table --------------------------------
    typedef struct {
        int unsigned cyc;
        logic [3:0]  req0;
        logic [3:0]  req_hold;
        logic [17:0] exp;
    } vec_t;

    vec_t vq[$];

    task automatic add_vec(input int unsigned c, input logic [3:0] r0,
                           input logic [3:0] rh, input logic [17:0] e);
        vec_t v;
        v.cyc = c; v.req0 = r0; v.req_hold = rh; v.exp = e;
        vq.push_back(v);
    endtask

    initial begin
        logic [3:0] rr;

        add_vec( 0, 4'b0001, 4'b0001, pack(LR, LR, LR, LR, 4'b0000, 2'd3));
        add_vec(20, 4'b0000, 4'b0000, pack(LR, LR, LR, LR, 4'b0000, 2'd3));
        add_vec( 1, 4'b0001, 4'b0001, pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        add_vec(40, 4'b0001, 4'b0001, pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        add_vec( 6, 4'b0011, 4'b0011, pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        add_vec( 7, 4'b0011, 4'b0011, pack(LR, LR, LR, LY, 4'b0001, 2'd0));
        add_vec( 8, 4'b0011, 4'b0011, pack(LR, LR, LR, LY, 4'b0001, 2'd0));
        add_vec( 9, 4'b0011, 4'b0011, pack(LR, LR, LR, LR, 4'b0000, 2'd0));
        add_vec(10, 4'b0011, 4'b0011, pack(LR, LR, LG, LR, 4'b0010, 2'd1));
        add_vec( 3, 4'b0001, 4'b0000, pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        add_vec( 4, 4'b0001, 4'b0000, pack(LR, LR, LR, LY, 4'b0001, 2'd0));
        add_vec( 6, 4'b0001, 4'b0000, pack(LR, LR, LR, LR, 4'b0000, 2'd0));
        add_vec( 7, 4'b0001, 4'b0000, pack(LR, LR, LR, LR, 4'b0000, 2'd0));
        add_vec( 1, 4'b0101, 4'b0101, pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        add_vec( 9, 4'b0101, 4'b0101, pack(LR, LR, LR, LR, 4'b0000, 2'd0));
        add_vec(10, 4'b0101, 4'b0101, pack(LR, LG, LR, LR, 4'b0100, 2'd2));

        foreach (vq[i]) begin
            do_reset();
            for (int unsigned c = 0; c < vq[i].cyc; c++) begin
                advance(1'b0, (c == 0) ? vq[i].req0 : vq[i].req_hold);
            end
            check($sformatf("vec%0d_cyc%0d", i, vq[i].cyc), out_a(), vq[i].exp);
        end

        // Reset during S yellow: all red on the very next cycle.
        do_reset();
        for (int c = 0; c < 7; c++) advance(1'b0, 4'b0011);
        check("rst_pre_yellow", out_a(), pack(LR, LR, LR, LY, 4'b0001, 2'd0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_yellow", out_a(), pack(LR, LR, LR, LR, 4'b0000, 2'd3));

`ifdef TRAFFIC_PREEMPT_EN
        // Preempt W during S green at e=0.
        do_reset();
        advance(1'b0, 4'b0001);
        check("pre_s_green", out_a(), pack(LR, LR, LR, LG, 4'b0001, 2'd0));
        preempt = 4'b1000;
        advance(1'b0, 4'b0001);
        check("pre_s_yellow", out_a(), pack(LR, LR, LR, LY, 4'b0001, 2'd0));
        advance(1'b0, 4'b0001);
        advance(1'b0, 4'b0001);
        check("pre_allred", out_a(), pack(LR, LR, LR, LR, 4'b0000, 2'd0));
        advance(1'b0, 4'b0001);
        check("pre_w_green", out_a(), pack(LG, LR, LR, LR, 4'b1000, 2'd3));
        preempt = 4'b0000;
`endif

        // Randomized demand against the reference model, both configurations.
        do_reset();
        rr = 4'b0000;
        for (int c = 0; c < 1500; c++) begin
            check($sformatf("rand_a_c%0d", c), out_a(), model_out(0));
            check($sformatf("rand_b_c%0d", c), out_b(), model_out(1));
            if ($urandom_range(0, 5) == 0) rr = 4'($urandom_range(0, 15));
            advance(($urandom_range(0, 199) == 0), rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
